freq_collect8: RTL and testbench

Upstream front end of the 8-way sort network in the Huffman encoder.
- Accepts a stream of 3-bit symbol indices and counts occurrences per symbol over one frame.
- At frame end, presents eight packed words {count, symbol id} to the sorter under a valid/ready handshake.
- Holds the words stable until consumed, then clears for the next frame.

---
 rtl/freq_collect8.sv | 119 +++++++++++
 tb/tb_freq_collect8.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_collect8.sv
// Per-frame symbol frequency collector feeding the 8-way Huffman sort network.
// Define FREQ_SAT_EN to make the per-symbol counters saturate instead of wrapping.
module freq_collect8 #(
    parameter int DSIZE  = 18,
    parameter int OFFSET = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [2:0]       sym_data,
    input  logic             sym_last,
    output logic [DSIZE-1:0] freq0,
    output logic [DSIZE-1:0] freq1,
    output logic [DSIZE-1:0] freq2,
    output logic [DSIZE-1:0] freq3,
    output logic [DSIZE-1:0] freq4,
    output logic [DSIZE-1:0] freq5,
    output logic [DSIZE-1:0] freq6,
    output logic [DSIZE-1:0] freq7,
    output logic             freq_valid,
    input  logic             freq_ready,
    output logic             ovf
);

    localparam int CW = DSIZE - OFFSET;
    localparam logic [CW-1:0] CMAX = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CW-1:0]    r_cnt [8];
    logic             r_ovf;
    logic             r_sym_ready;
    logic             r_freq_valid;

    logic             w_accept;
    logic             w_handshake;
    logic [CW-1:0]    w_cur;
    logic [CW-1:0]    w_inc;
    logic             w_at_max;
    logic [DSIZE-1:0] w_freq [8];

    assign w_accept    = sym_valid & r_sym_ready;
    assign w_handshake = r_freq_valid & freq_ready;
    assign w_cur       = r_cnt[sym_data];
    assign w_at_max    = (w_cur == CMAX);

`ifdef FREQ_SAT_EN
    assign w_inc = w_at_max ? w_cur : w_cur + CW'(1);
`else
    assign w_inc = w_cur + CW'(1);
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_COUNT: begin
                if (w_accept) begin
                    w_state_nxt = sym_last ? S_HOLD : S_COUNT;
                end
            end
            S_HOLD: begin
                if (w_handshake) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshakes are registered off the next state so the sym_ready/freq_valid pair never overlaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sym_ready  <= 1'b1;
            r_freq_valid <= 1'b0;
            r_ovf        <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_sym_ready  <= (w_state_nxt != S_HOLD);
            r_freq_valid <= (w_state_nxt == S_HOLD);
            if (w_handshake) begin
                r_ovf <= 1'b0;
                for (int i = 0; i < 8; i++) begin
                    r_cnt[i] <= '0;
                end
            end else if (w_accept) begin
                r_cnt[sym_data] <= w_inc;
                if (w_at_max) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_word
        assign w_freq[g] = {r_cnt[g], OFFSET'(g)};
    end

    assign freq0      = w_freq[0];
    assign freq1      = w_freq[1];
    assign freq2      = w_freq[2];
    assign freq3      = w_freq[3];
    assign freq4      = w_freq[4];
    assign freq5      = w_freq[5];
    assign freq6      = w_freq[6];
    assign freq7      = w_freq[7];
    assign sym_ready  = r_sym_ready;
    assign freq_valid = r_freq_valid;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_freq_collect8.sv
// Scoreboard bench for freq_collect8: a counting model queues expected frames, a monitor pops them.
module tb_freq_collect8;

    typedef struct packed {
        logic [7:0][9:0] cnt;
        logic            ovf;
        int              beats;
    } frame_t;

    logic        clk;
    logic        rst;
    logic        symValid;
    logic        symReady;
    logic [2:0]  symData;
    logic        symLast;
    logic [17:0] freqWord [8];
    logic        freqValid;
    logic        freqReady;
    logic        ovf;

    int     checks = 0;
    int     errors = 0;
    int     cycle = 0;
    int     framesIn = 0;
    int     framesOut = 0;
    int     modelCnt [8];
    int     modelBeats = 0;
    int     lastAcceptCycle = 0;
    bit     randReady = 0;
    bit     haveFrame = 0;
    frame_t expQ [$];
    frame_t cur;

    freq_collect8 #(.DSIZE(18), .OFFSET(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .sym_valid  (symValid),
        .sym_ready  (symReady),
        .sym_data   (symData),
        .sym_last   (symLast),
        .freq0      (freqWord[0]),
        .freq1      (freqWord[1]),
        .freq2      (freqWord[2]),
        .freq3      (freqWord[3]),
        .freq4      (freqWord[4]),
        .freq5      (freqWord[5]),
        .freq6      (freqWord[6]),
        .freq7      (freqWord[7]),
        .freq_valid (freqValid),
        .freq_ready (freqReady),
        .ovf        (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
            #1;
            if (randReady) freqReady = 1'($urandom_range(0, 1));
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] word(input int n, input int c);
        return {10'(c), 8'(n)};
    endfunction

    // Expected counts come straight from the symbol tallies: clamp or modulo, overflow when >1023.
    task automatic pushFrame();
        frame_t e;
        int c;
        e.ovf = 1'b0;
        for (int n = 0; n < 8; n++) begin
`ifdef FREQ_SAT_EN
            c = (modelCnt[n] > 1023) ? 1023 : modelCnt[n];
`else
            c = modelCnt[n] % 1024;
`endif
            e.cnt[n] = 10'(c);
            if (modelCnt[n] > 1023) e.ovf = 1'b1;
        end
        e.beats = modelBeats;
        expQ.push_back(e);
        framesIn++;
        for (int n = 0; n < 8; n++) modelCnt[n] = 0;
        modelBeats = 0;
    endtask

    task automatic clearModel();
        for (int n = 0; n < 8; n++) modelCnt[n] = 0;
        modelBeats = 0;
    endtask

    task automatic applyStimulus(input logic [2:0] s, input logic last);
        bit done;
        bit ok;
        int guard;
        done = 0;
        guard = 0;
        symValid = 1'b1;
        symData = s;
        symLast = last;
        while (!done && guard < 2000) begin
            @(negedge clk);
            ok = (symReady === 1'b1);
            @(posedge clk);
            #1;
            if (ok) done = 1;
            guard++;
        end
        symValid = 1'b0;
        symLast = 1'b0;
        if (!done) begin
            checkOutput("accept timeout", 0, 1);
        end else begin
            modelCnt[s]++;
            modelBeats++;
            lastAcceptCycle = cycle;
            if (last) pushFrame();
        end
    endtask

    task automatic handshake();
        freqReady = 1'b1;
        @(posedge clk);
        #1;
        freqReady = 1'b0;
    endtask

    // Monitor: pop one expected frame per freq_valid episode and hold it against the outputs until consumed.
    initial begin
        int sum;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 || freqValid !== 1'b1) begin
                haveFrame = 0;
            end else begin
                if (!haveFrame) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected frame", 1, 0);
                    end else begin
                        cur = expQ.pop_front();
                        haveFrame = 1;
                        framesOut++;
                        sum = 0;
                        for (int n = 0; n < 8; n++) begin
                            checkOutput($sformatf("frame word%0d", n), 32'(freqWord[n]), 32'(word(n, int'(cur.cnt[n]))));
                            sum += int'(freqWord[n][17:8]);
                        end
                        checkOutput("frame ovf", 32'(ovf), 32'(cur.ovf));
                        if (!cur.ovf) checkOutput("frame sum", sum, cur.beats);
                    end
                end else begin
                    for (int n = 0; n < 8; n++)
                        checkOutput($sformatf("hold word%0d", n), 32'(freqWord[n]), 32'(word(n, int'(cur.cnt[n]))));
                    checkOutput("hold ovf", 32'(ovf), 32'(cur.ovf));
                end
                if (freqReady === 1'b1) haveFrame = 0;
            end
        end
    end

    initial begin
        int prev;
        bit drained;
        rst = 1'b1;
        symValid = 1'b0;
        symData = 3'd0;
        symLast = 1'b0;
        freqReady = 1'b0;
        clearModel();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        checkOutput("reset freq_valid", 32'(freqValid), 0);
        checkOutput("reset sym_ready", 32'(symReady), 1);
        checkOutput("reset ovf", 32'(ovf), 0);
        checkOutput("reset freq3", 32'(freqWord[3]), 32'h00003);
        @(posedge clk);
        #1;

        applyStimulus(3'd2, 1'b0);
        applyStimulus(3'd2, 1'b0);
        applyStimulus(3'd5, 1'b0);
        applyStimulus(3'd2, 1'b1);
        @(negedge clk);
        checkOutput("first freq_valid", 32'(freqValid), 1);
        checkOutput("first freq2", 32'(freqWord[2]), 32'({10'd3, 8'd2}));
        checkOutput("first freq5", 32'(freqWord[5]), 32'({10'd1, 8'd5}));
        @(posedge clk);
        #1;

        symValid = 1'b1;
        symData = 3'd4;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp sym_ready", 32'(symReady), 0);
            checkOutput("bp freq4", 32'(freqWord[4]), 32'(word(4, 0)));
            @(posedge clk);
            #1;
        end
        handshake();
        symValid = 1'b0;
        @(negedge clk);
        checkOutput("post hs sym_ready", 32'(symReady), 1);
        checkOutput("post hs freq_valid", 32'(freqValid), 0);
        for (int n = 0; n < 8; n++)
            checkOutput($sformatf("post hs word%0d", n), 32'(freqWord[n]), 32'(word(n, 0)));
        @(posedge clk);
        #1;

        freqReady = 1'b1;
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(3'd7, 1'b1);
            if (k > 0) checkOutput("b2b period", lastAcceptCycle - prev, 2);
            prev = lastAcceptCycle;
        end
        @(posedge clk);
        #1;
        freqReady = 1'b0;

        for (int i = 0; i < 1025; i++) applyStimulus(3'd0, (i == 1024));
        @(negedge clk);
        checkOutput("ovf set", 32'(ovf), 1);
        @(posedge clk);
        #1;
        handshake();
        @(negedge clk);
        checkOutput("ovf cleared", 32'(ovf), 0);
        checkOutput("ovf freq0 cleared", 32'(freqWord[0]), 32'(word(0, 0)));
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) applyStimulus(3'(i + 3), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearModel();
        @(negedge clk);
        checkOutput("midrst freq_valid", 32'(freqValid), 0);
        checkOutput("midrst sym_ready", 32'(symReady), 1);
        for (int n = 0; n < 8; n++)
            checkOutput($sformatf("midrst word%0d", n), 32'(freqWord[n]), 32'(word(n, 0)));
        @(posedge clk);
        #1;
        applyStimulus(3'd1, 1'b1);
        @(negedge clk);
        checkOutput("midrst freq1", 32'(freqWord[1]), 32'({10'd1, 8'd1}));
        @(posedge clk);
        #1;
        handshake();

        randReady = 1;
        for (int f = 0; f < 8; f++) begin
            for (int b = 0; b < 25; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                applyStimulus(3'($urandom_range(0, 7)), (b == 24));
            end
        end

        drained = 0;
        for (int i = 0; i < 1000 && !drained; i++) begin
            @(negedge clk);
            if (expQ.size() == 0 && freqValid === 1'b0) drained = 1;
        end
        checkOutput("drain", 32'(drained), 1);
        checkOutput("frame count", framesOut, framesIn);
        randReady = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
